// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW program loader.
// Optional checksum: define VLIW_LOADER_CHECKSUM_EN.
package vliw_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    LOAD,
    WRITE,
    RUN
  } ld_state_e;

endpackage

// File: rtl/vliw_loader_bundle_packer.sv
// Slot register array and slot counter for one VLIW bundle.
// Slots above the current word read as NOP, so a short bundle is padded.
module bundle_packer
  import vliw_pkg::*;
#(
  parameter int CORES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    push,
  input  logic                    last,
  input  logic [WORD_W-1:0]       data,
  output logic [WORD_W*CORES-1:0] bundle,
  output logic                    full
);

  localparam int SW = (CORES > 1) ? $clog2(CORES) : 1;

  logic [SW-1:0]     slot;
  logic [WORD_W-1:0] regs [CORES];

  assign full = (slot == SW'(CORES - 1)) || last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
      for (int i = 0; i < CORES; i++)
        regs[i] <= NOP_WORD;
    end else if (clr) begin
      slot <= '0;
    end else if (push) begin
      regs[slot] <= data;
      slot <= full ? '0 : slot + 1'b1;
    end
  end

  // Packed view includes the word being accepted this cycle.
  always_comb begin
    bundle = '0;
    for (int i = 0; i < CORES; i++) begin
      if (SW'(i) < slot)
        bundle[i*WORD_W +: WORD_W] = regs[i];
      else if (SW'(i) == slot)
        bundle[i*WORD_W +: WORD_W] = data;
      else
        bundle[i*WORD_W +: WORD_W] = NOP_WORD;
    end
  end

endmodule

// File: rtl/vliw_loader.sv
// Loads a program into instruction memory as VLIW bundles, holding the CPU.
// Optional checksum: define VLIW_LOADER_CHECKSUM_EN.
module vliw_loader
  import vliw_pkg::*;
#(
  parameter int CORES = 1,
  parameter int DEPTH = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W-1:0]       in_data,
  input  logic                    in_last,
  input  logic                    reload,
  output logic                    im_we,
  output logic [31:0]             im_addr,
  output logic [WORD_W*CORES-1:0] im_data,
  output logic                    cpu_hold,
  output logic                    done,
  output logic                    err,
  output logic [WORD_W-1:0]       checksum
);

  localparam int CW = $clog2(DEPTH + 1);

  ld_state_e               state;
  logic [CW-1:0]           count;
  logic                    last_q;
  logic                    accept;
  logic                    restart;
  logic                    full;
  logic [WORD_W*CORES-1:0] bundle;

  assign accept  = in_valid && in_ready;
  assign restart = (state == RUN) && reload;

  bundle_packer #(
    .CORES (CORES)
  ) u_pack (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (restart),
    .push   (accept),
    .last   (in_last),
    .data   (in_data),
    .bundle (bundle),
    .full   (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      count    <= '0;
      last_q   <= 1'b0;
      in_ready <= 1'b1;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_data  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      im_we <= 1'b0;
      unique case (state)
        LOAD: begin
          if (accept && full) begin
            state    <= WRITE;
            in_ready <= 1'b0;
            last_q   <= in_last;
            // Past capacity, keep draining but never write.
            if (count < CW'(DEPTH)) begin
              im_we   <= 1'b1;
              im_addr <= 32'(count) << 2;
              im_data <= bundle;
              count   <= count + 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (last_q) begin
            state    <= RUN;
            cpu_hold <= 1'b0;
            done     <= !err;
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          if (reload) begin
            state    <= LOAD;
            count    <= '0;
            last_q   <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef VLIW_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      checksum <= '0;
    else if (restart)
      checksum <= '0;
    else if (accept)
      checksum <= checksum ^ in_data;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_vliw_loader.sv
// Scoreboard bench for vliw_loader across three configurations.
// Checksum expectations follow VLIW_LOADER_CHECKSUM_EN.
module tb_vliw_loader;

`ifdef VLIW_LOADER_CHECKSUM_EN
  localparam logic [31:0] CS_EXP = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CS_EXP = 32'h0000_0000;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [63:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn [3];
  logic        iv [3];
  logic        ir [3];
  logic [31:0] id [3];
  logic        il [3];
  logic        rl [3];
  logic        we [3];
  logic [31:0] ad [3];
  logic        hd [3];
  logic        dn [3];
  logic        er [3];
  logic [31:0] cs [3];
  logic [31:0] od0;
  logic [63:0] od1;
  logic [31:0] od2;

  wr_t q0[$];
  wr_t q1[$];
  wr_t q2[$];

  int n_chk  = 0;
  int n_pass = 0;

  vliw_loader #(.CORES(1), .DEPTH(1024)) u_d0 (
    .clk(clk), .rst_n(rn[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .in_last(il[0]), .reload(rl[0]), .im_we(we[0]),
    .im_addr(ad[0]), .im_data(od0), .cpu_hold(hd[0]), .done(dn[0]),
    .err(er[0]), .checksum(cs[0])
  );

  vliw_loader #(.CORES(2), .DEPTH(16)) u_d1 (
    .clk(clk), .rst_n(rn[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .in_last(il[1]), .reload(rl[1]), .im_we(we[1]),
    .im_addr(ad[1]), .im_data(od1), .cpu_hold(hd[1]), .done(dn[1]),
    .err(er[1]), .checksum(cs[1])
  );

  vliw_loader #(.CORES(1), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rn[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(id[2]), .in_last(il[2]), .reload(rl[2]), .im_we(we[2]),
    .im_addr(ad[2]), .im_data(od2), .cpu_hold(hd[2]), .done(dn[2]),
    .err(er[2]), .checksum(cs[2])
  );

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic expect_wr(int k, logic [31:0] a, logic [63:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic logic [63:0] odat(int k);
    case (k)
      0: return {32'h0, od0};
      1: return od1;
      default: return {32'h0, od2};
    endcase
  endfunction

  // Monitor: every write strobe pops one expected bundle.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rn[k] && we[k]) begin
        wr_t e;
        int  got;
        got = 0;
        e = '0;
        case (k)
          0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1; end
        endcase
        if (got == 0) begin
          n_chk++;
          $display("FAIL d%0d_unexpected_write: got addr %h required none",
                   k, ad[k]);
        end else begin
          check($sformatf("d%0d_addr", k), {32'h0, ad[k]}, {32'h0, e.a});
          check($sformatf("d%0d_data", k), odat(k), e.d);
          check($sformatf("d%0d_hold_in_write", k), {63'h0, hd[k]}, 64'd1);
        end
      end
    end
  end

  task automatic send(int k, logic [31:0] w, logic last, int gap);
    int n = 0;
    @(negedge clk);
    iv[k] = 1'b1;
    id[k] = w;
    il[k] = last;
    while (!ir[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_chk++;
      $display("FAIL d%0d_accept_timeout: got no accept required accept of %h",
               k, w);
    end else begin
      @(posedge clk);
    end
    #1;
    iv[k] = 1'b0;
    il[k] = 1'b0;
    id[k] = '0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_reload(int k);
    @(negedge clk);
    rl[k] = 1'b1;
    @(negedge clk);
    rl[k] = 1'b0;
    check($sformatf("d%0d_reload_hold", k), {63'h0, hd[k]}, 64'd1);
    check($sformatf("d%0d_reload_ready", k), {63'h0, ir[k]}, 64'd1);
    check($sformatf("d%0d_reload_done", k), {63'h0, dn[k]}, 64'd0);
    check($sformatf("d%0d_reload_err", k), {63'h0, er[k]}, 64'd0);
    check($sformatf("d%0d_reload_cs", k), {32'h0, cs[k]}, 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rn[k] = 1'b0;
      iv[k] = 1'b0;
      id[k] = '0;
      il[k] = 1'b0;
      rl[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_ready", {63'h0, ir[0]}, 64'd1);
    check("rst_we", {63'h0, we[0]}, 64'd0);
    check("rst_addr", {32'h0, ad[0]}, 64'd0);
    check("rst_data", odat(1), 64'd0);
    check("rst_hold", {63'h0, hd[0]}, 64'd1);
    check("rst_done", {63'h0, dn[0]}, 64'd0);
    check("rst_err", {63'h0, er[0]}, 64'd0);
    check("rst_cs", {32'h0, cs[0]}, 64'd0);
    for (int k = 0; k < 3; k++) rn[k] = 1'b1;

    // CORES=1: three words, hold falls right after the last write.
    expect_wr(0, 32'd0, 64'h11);
    expect_wr(0, 32'd4, 64'h22);
    expect_wr(0, 32'd8, 64'h33);
    send(0, 32'h11, 1'b0, 0);
    send(0, 32'h22, 1'b0, 0);
    send(0, 32'h33, 1'b1, 0);
    @(negedge clk);
    check("d0_final_we", {63'h0, we[0]}, 64'd1);
    check("d0_final_hold", {63'h0, hd[0]}, 64'd1);
    @(negedge clk);
    check("d0_run_hold", {63'h0, hd[0]}, 64'd0);
    check("d0_run_done", {63'h0, dn[0]}, 64'd1);
    check("d0_run_err", {63'h0, er[0]}, 64'd0);
    check("d0_run_ready", {63'h0, ir[0]}, 64'd0);

    // CORES=2 with valid toggling: {B,A} then {NOP,C}.
    expect_wr(1, 32'd0, {32'hBBBB_0002, 32'hAAAA_0001});
    expect_wr(1, 32'd4, {32'h0000_0000, 32'hCCCC_0003});
    send(1, 32'hAAAA_0001, 1'b0, 1);
    send(1, 32'hBBBB_0002, 1'b0, 1);
    send(1, 32'hCCCC_0003, 1'b1, 1);
    repeat (3) @(negedge clk);
    check("d1_done", {63'h0, dn[1]}, 64'd1);
    check("d1_hold", {63'h0, hd[1]}, 64'd0);

    // DEPTH=2 overflow: two writes, all four words drained.
    expect_wr(2, 32'd0, 64'h1);
    expect_wr(2, 32'd4, 64'h2);
    send(2, 32'h1, 1'b0, 0);
    send(2, 32'h2, 1'b0, 0);
    send(2, 32'h3, 1'b0, 0);
    send(2, 32'h4, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("d2_err", {63'h0, er[2]}, 64'd1);
    check("d2_done", {63'h0, dn[2]}, 64'd0);
    check("d2_hold", {63'h0, hd[2]}, 64'd0);
    check("d2_ready", {63'h0, ir[2]}, 64'd0);

    // Reload and checksum.
    pulse_reload(0);
    expect_wr(0, 32'd0, 64'hF0F0_0000);
    expect_wr(0, 32'd4, 64'h0F0F_FFFF);
    send(0, 32'hF0F0_0000, 1'b0, 0);
    send(0, 32'h0F0F_FFFF, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("d0_checksum", {32'h0, cs[0]}, {32'h0, CS_EXP});
    check("d0_done2", {63'h0, dn[0]}, 64'd1);
    pulse_reload(0);

    // Reset mid-bundle: no write, then a clean bundle from word 0.
    pulse_reload(1);
    send(1, 32'h1234_5678, 1'b0, 0);
    @(negedge clk);
    rn[1] = 1'b0;
    #1;
    check("d1_mid_rst_ready", {63'h0, ir[1]}, 64'd1);
    check("d1_mid_rst_we", {63'h0, we[1]}, 64'd0);
    check("d1_mid_rst_addr", {32'h0, ad[1]}, 64'd0);
    check("d1_mid_rst_data", od1, 64'd0);
    check("d1_mid_rst_hold", {63'h0, hd[1]}, 64'd1);
    check("d1_mid_rst_done", {63'h0, dn[1]}, 64'd0);
    @(negedge clk);
    rn[1] = 1'b1;
    expect_wr(1, 32'd0, {32'h9ABC_DEF0, 32'h5555_6666});
    send(1, 32'h5555_6666, 1'b0, 0);
    send(1, 32'h9ABC_DEF0, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("d1_done_after_rst", {63'h0, dn[1]}, 64'd1);

    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
